// File: rtl/fifo_rd_ctrl.sv
// Read-side pointer controller for a dual-clock FIFO: synchronizes the Gray write pointer,
// owns the binary/Gray read pointer and derives fill count, empty and sticky error flags.
module fifo_rd_ctrl #(
  parameter int unsigned AW         = 4,
  parameter int unsigned SYNCS      = 2,
  parameter int unsigned PROG_EMPTY = 2
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic [AW:0]   wr_ptr_gray,
  input  logic          rd_en,
  input  logic          err_clr,
  output logic [AW-1:0] rd_addr,
  output logic [AW:0]   rd_ptr_gray,
  output logic          rd_fire,
  output logic [AW:0]   count,
  output logic          empty,
  output logic          prog_empty,
  output logic          underflow,
  output logic          ptr_err
);

  localparam int unsigned PW           = AW + 1;
  localparam logic [AW:0] ProgEmptyLvl = PW'(PROG_EMPTY);
  localparam logic [AW:0] DepthLvl     = PW'(1) << AW;

  logic [AW:0] sync_q [SYNCS];
  logic [AW:0] sync_d [SYNCS];
  logic [AW:0] wr_gray_s;
  logic [AW:0] wr_bin_d, wr_bin_q;
  logic [AW:0] rd_ptr_bin_d, rd_ptr_bin_q;
  logic [AW:0] rd_ptr_gray_d, rd_ptr_gray_q;
  logic        underflow_d, underflow_q;
  logic        ptr_err_d, ptr_err_q;

  // First stage samples the asynchronous pointer directly; no logic in front of it.
  always_comb begin
    sync_d[0] = wr_ptr_gray;
    for (int i = 1; i < int'(SYNCS); i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  assign wr_gray_s = sync_q[SYNCS-1];

  // Binary bit i is the XOR of Gray bits AW..i.
  always_comb begin
    wr_bin_d = '0;
    for (int i = 0; i <= int'(AW); i++) begin
      wr_bin_d[i] = ^(wr_gray_s >> i);
    end
  end

  // Decoded purely from flops; only rd_fire additionally sees rd_en.
  always_comb begin
    count      = wr_bin_q - rd_ptr_bin_q;
    empty      = (count == '0);
    prog_empty = (count <= ProgEmptyLvl);
    rd_fire    = rd_en & ~empty;
  end

  // Gray is derived from the same next value so both pointers move on the same edge.
  always_comb begin
    rd_ptr_bin_d  = rd_ptr_bin_q + PW'(rd_fire);
    rd_ptr_gray_d = rd_ptr_bin_d ^ (rd_ptr_bin_d >> 1);
  end

  // Sticky flags: a set condition in the same cycle as err_clr wins.
  always_comb begin
    underflow_d = (rd_en & empty) | (underflow_q & ~err_clr);
    ptr_err_d   = (count > DepthLvl) | (ptr_err_q & ~err_clr);
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int i = 0; i < int'(SYNCS); i++) begin
        sync_q[i] <= '0;
      end
      wr_bin_q      <= '0;
      rd_ptr_bin_q  <= '0;
      rd_ptr_gray_q <= '0;
      underflow_q   <= 1'b0;
      ptr_err_q     <= 1'b0;
    end else begin
      for (int i = 0; i < int'(SYNCS); i++) begin
        sync_q[i] <= sync_d[i];
      end
      wr_bin_q      <= wr_bin_d;
      rd_ptr_bin_q  <= rd_ptr_bin_d;
      rd_ptr_gray_q <= rd_ptr_gray_d;
      underflow_q   <= underflow_d;
      ptr_err_q     <= ptr_err_d;
    end
  end

  assign rd_addr     = rd_ptr_bin_q[AW-1:0];
  assign rd_ptr_gray = rd_ptr_gray_q;
  assign underflow   = underflow_q;
  assign ptr_err     = ptr_err_q;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: reset checks, a vector table for latency/drain/err_clr, hand
// sequences for wrap and corrupt pointer, then random traffic against a behavioural model.
module tb_fifo_rd_ctrl;

  localparam int unsigned AW         = 3;
  localparam int unsigned SYNCS      = 2;
  localparam int unsigned PROG_EMPTY = 2;
  localparam int unsigned DEPTH      = 1 << AW;
  localparam int unsigned PMASK      = 2 * DEPTH - 1;

  logic          clk = 1'b0;
  logic          nreset;
  logic [AW:0]   wr_ptr_gray;
  logic          rd_en;
  logic          err_clr;
  logic [AW-1:0] rd_addr;
  logic [AW:0]   rd_ptr_gray;
  logic          rd_fire;
  logic [AW:0]   count;
  logic          empty;
  logic          prog_empty;
  logic          underflow;
  logic          ptr_err;

  fifo_rd_ctrl #(
    .AW        (AW),
    .SYNCS     (SYNCS),
    .PROG_EMPTY(PROG_EMPTY)
  ) dut (
    .clk        (clk),
    .nreset     (nreset),
    .wr_ptr_gray(wr_ptr_gray),
    .rd_en      (rd_en),
    .err_clr    (err_clr),
    .rd_addr    (rd_addr),
    .rd_ptr_gray(rd_ptr_gray),
    .rd_fire    (rd_fire),
    .count      (count),
    .empty      (empty),
    .prog_empty (prog_empty),
    .underflow  (underflow),
    .ptr_err    (ptr_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [AW:0] wr_gray;
    bit          ren;
    bit          clr;
    int unsigned cnt;
    bit          emp;
    bit          pemp;
    bit          fire;
    int unsigned addr;
    logic [AW:0] rgray;
    bit          uf;
    bit          perr;
  } vec_t;

  vec_t vecs[16];

  // Behavioural model: total reads accepted, history of applied write pointers.
  int unsigned m_rd;
  int unsigned m_hist[$];
  bit          m_uf;
  bit          m_pe;
  int          dut_fires;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input int unsigned cnt, input bit emp,
                           input bit pemp, input bit fire, input int unsigned addr,
                           input logic [AW:0] rg, input bit uf, input bit pe);
    chk({tag, ".count"}, 32'(count), cnt);
    chk({tag, ".empty"}, 32'(empty), 32'(emp));
    chk({tag, ".prog_empty"}, 32'(prog_empty), 32'(pemp));
    chk({tag, ".rd_fire"}, 32'(rd_fire), 32'(fire));
    chk({tag, ".rd_addr"}, 32'(rd_addr), addr);
    chk({tag, ".rd_ptr_gray"}, 32'(rd_ptr_gray), 32'(rg));
    chk({tag, ".underflow"}, 32'(underflow), 32'(uf));
    chk({tag, ".ptr_err"}, 32'(ptr_err), 32'(pe));
  endtask

  function automatic logic [AW:0] to_gray(input int unsigned b);
    logic [AW:0] v;
    v = b[AW:0];
    return v ^ (v >> 1);
  endfunction

  function automatic vec_t mk(input logic [AW:0] wg, input bit ren, input bit clr,
                              input int unsigned cnt, input bit emp, input bit pemp,
                              input bit fire, input int unsigned addr,
                              input logic [AW:0] rg, input bit uf, input bit pe);
    vec_t v;
    v.wr_gray = wg;  v.ren  = ren;  v.clr  = clr;  v.cnt   = cnt;
    v.emp     = emp; v.pemp = pemp; v.fire = fire; v.addr  = addr;
    v.rgray   = rg;  v.uf   = uf;   v.perr = pe;
    return v;
  endfunction

  // Write value visible as wr_bin_q: the one applied SYNCS+1 edges ago.
  function automatic int unsigned m_seen();
    if (m_hist.size() < SYNCS + 1) return 0;
    return m_hist[m_hist.size() - (SYNCS + 1)];
  endfunction

  task automatic do_reset();
    nreset      = 1'b0;
    rd_en       = 1'b0;
    err_clr     = 1'b0;
    wr_ptr_gray = '0;
    m_rd        = 0;
    m_uf        = 1'b0;
    m_pe        = 1'b0;
    m_hist.delete();
    repeat (2) @(posedge clk);
    #1 nreset = 1'b1;
  endtask

  // Entered at posedge+1; drives one cycle, checks, advances the model across the edge.
  task automatic model_cycle(input string tag, input int unsigned wbin, input bit ren,
                             input bit clr);
    int unsigned cnt;
    bit          fire;
    wr_ptr_gray = to_gray(wbin & PMASK);
    rd_en       = ren;
    err_clr     = clr;
    #1;
    cnt  = (m_seen() - m_rd) & PMASK;
    fire = ren && (cnt != 0);
    check_all(tag, cnt, cnt == 0, cnt <= PROG_EMPTY, fire, m_rd & (DEPTH - 1),
              to_gray(m_rd & PMASK), m_uf, m_pe);
    dut_fires += int'(rd_fire);
    m_uf = (ren && cnt == 0) || (m_uf && !clr);
    m_pe = (cnt > DEPTH) || (m_pe && !clr);
    if (fire) m_rd++;
    m_hist.push_back(wbin);
    if (m_hist.size() > 8) void'(m_hist.pop_front());
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end

  initial begin
    int unsigned wtot;
    int          rd_pct;
    logic [AW:0] mixed;

    // Reset held with arbitrary inputs.
    nreset      = 1'b0;
    rd_en       = 1'b1;
    err_clr     = 1'($urandom);
    wr_ptr_gray = AW'($urandom);
    repeat (3) @(posedge clk);
    #1;
    check_all("rst_hold", 0, 1, 1, 0, 0, '0, 0, 0);
    rd_en       = 1'b0;
    err_clr     = 1'b0;
    wr_ptr_gray = '0;
    nreset      = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      check_all($sformatf("rst_idle%0d", c), 0, 1, 1, 0, 0, '0, 0, 0);
    end

    // Latency, drain and err_clr: write pointer 0111 (binary 5).
    vecs[0]  = mk(4'b0111, 0, 0, 0, 1, 1, 0, 0, 4'b0000, 0, 0);
    vecs[1]  = mk(4'b0111, 0, 0, 0, 1, 1, 0, 0, 4'b0000, 0, 0);
    vecs[2]  = mk(4'b0111, 0, 0, 0, 1, 1, 0, 0, 4'b0000, 0, 0);
    vecs[3]  = mk(4'b0111, 1, 0, 5, 0, 0, 1, 0, 4'b0000, 0, 0);
    vecs[4]  = mk(4'b0111, 1, 0, 4, 0, 0, 1, 1, 4'b0001, 0, 0);
    vecs[5]  = mk(4'b0111, 1, 0, 3, 0, 0, 1, 2, 4'b0011, 0, 0);
    vecs[6]  = mk(4'b0111, 1, 0, 2, 0, 1, 1, 3, 4'b0010, 0, 0);
    vecs[7]  = mk(4'b0111, 1, 0, 1, 0, 1, 1, 4, 4'b0110, 0, 0);
    vecs[8]  = mk(4'b0111, 1, 0, 0, 1, 1, 0, 5, 4'b0111, 0, 0);
    vecs[9]  = mk(4'b0111, 0, 0, 0, 1, 1, 0, 5, 4'b0111, 1, 0);
    vecs[10] = mk(4'b0111, 0, 1, 0, 1, 1, 0, 5, 4'b0111, 1, 0);
    vecs[11] = mk(4'b0111, 0, 1, 0, 1, 1, 0, 5, 4'b0111, 0, 0);
    vecs[12] = mk(4'b0111, 0, 0, 0, 1, 1, 0, 5, 4'b0111, 0, 0);
    vecs[13] = mk(4'b0111, 1, 1, 0, 1, 1, 0, 5, 4'b0111, 0, 0);
    vecs[14] = mk(4'b0111, 0, 0, 0, 1, 1, 0, 5, 4'b0111, 1, 0);
    vecs[15] = mk(4'b0111, 0, 1, 0, 1, 1, 0, 5, 4'b0111, 1, 0);
    for (int k = 0; k < 16; k++) begin
      wr_ptr_gray = vecs[k].wr_gray;
      rd_en       = vecs[k].ren;
      err_clr     = vecs[k].clr;
      #1;
      check_all($sformatf("vec%0d", k), vecs[k].cnt, vecs[k].emp, vecs[k].pemp, vecs[k].fire,
                vecs[k].addr, vecs[k].rgray, vecs[k].uf, vecs[k].perr);
      @(posedge clk);
      #1;
    end

    // Wrap: legal Gray steps to binary 16 while reading continuously.
    do_reset();
    dut_fires = 0;
    for (int w = 1; w <= 26; w++) begin
      model_cycle($sformatf("wrap%0d", w), (w > 16) ? 16 : w, 1'b1, 1'b0);
      chk("wrap.count_le_depth", 32'(count <= DEPTH), 1);
    end
    chk("wrap.fires", 32'(dut_fires), 16);
    chk("wrap.rd_ptr_gray", 32'(rd_ptr_gray), 0);
    chk("wrap.ptr_err", 32'(ptr_err), 0);

    // Corrupt pointer 1010 (binary 12) then asynchronous reset mid-cycle.
    do_reset();
    wr_ptr_gray = 4'b1010;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("bad%0d.count", c), 32'(count), (c >= 3) ? 12 : 0);
      chk($sformatf("bad%0d.ptr_err", c), 32'(ptr_err), (c >= 4) ? 1 : 0);
      @(posedge clk);
      #1;
    end
    #2 nreset = 1'b0;
    #1;
    check_all("async_rst", 0, 1, 1, 0, 0, '0, 0, 0);
    @(posedge clk);
    #1 nreset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk($sformatf("relearn%0d.count", c), 32'(count), (c >= 3) ? 12 : 0);
      @(posedge clk);
      #1;
    end

    // Random traffic: write-heavy then read-heavy phases.
    for (int phase = 0; phase < 2; phase++) begin
      do_reset();
      wtot   = 0;
      rd_pct = (phase == 0) ? 25 : 70;
      for (int n = 0; n < 400; n++) begin
        if ($urandom_range(0, 1) == 1 && (wtot - m_rd) < DEPTH) wtot++;
        model_cycle($sformatf("rnd%0d_%0d", phase, n), wtot,
                    $urandom_range(0, 99) < rd_pct, $urandom_range(0, 9) == 0);
      end
    end

    // Non-Gray jump after random traffic must latch ptr_err.
    mixed = to_gray((m_rd + 11) & PMASK);
    wr_ptr_gray = mixed;
    rd_en       = 1'b0;
    err_clr     = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("jump.count", 32'(count), 11);
    chk("jump.ptr_err", 32'(ptr_err), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
